// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle for multicycle_control.
// master: the control FSM (drives control strobes, observes opcode/flags/ready).
// slave : datapath and memories (drive opcode/flags/ready, observe control).
interface multicycle_control_if #(
    parameter int OPCODE_W = 11,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                imem_ready;
    logic                dmem_ready;
    logic                halt_req;

    logic [2:0]          state;
    logic                imem_req;
    logic                ir_write;
    logic                pc_write;
    logic                pc_src;
    logic                readreg2_control;
    logic                dmem_read;
    logic                dmem_write;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src;
    logic [1:0]          alu_op;
    logic                update_sreg;
    logic                instr_done;
    logic                illegal_op;
    logic                bus_error;
    logic                halted;
    logic [CNT_W-1:0]    retired_count;

    modport master (
        input  opcode, zero, imem_ready, dmem_ready, halt_req,
        output state, imem_req, ir_write, pc_write, pc_src, readreg2_control,
               dmem_read, dmem_write, mem_to_reg, reg_write, alu_src, alu_op,
               update_sreg, instr_done, illegal_op, bus_error, halted, retired_count
    );

    modport slave (
        output opcode, zero, imem_ready, dmem_ready, halt_req,
        input  state, imem_req, ir_write, pc_write, pc_src, readreg2_control,
               dmem_read, dmem_write, mem_to_reg, reg_write, alu_src, alu_op,
               update_sreg, instr_done, illegal_op, bus_error, halted, retired_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB with HALT, memory-wait timeout,
// illegal-opcode detection and retired-instruction counter.
// Ports: clk, reset (sync, active-high), bus (multicycle_control_if.master) carrying
// opcode/zero/ready/halt_req in and all control strobes, state and counters out.
module multicycle_control #(
    parameter int OPCODE_W    = 11,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_R, C_I, C_LD, C_ST, C_CBZ, C_CBNZ, C_B
    } cls_t;

    // Wait counter only needs to reach MEM_TIMEOUT-1: the miss seen at that value is the
    // one that would bring it to MEM_TIMEOUT, so that cycle decides the timeout.
    localparam int                WCNT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit                TIMEOUT_EN = (MEM_TIMEOUT > 0);

    state_t            r_state, w_next;
    cls_t              r_cls, w_dec_cls;
    logic [WCNT_W-1:0] r_wait, w_wait_next;
    logic              r_bus_error;
    logic [CNT_W-1:0]  r_retired;
    logic              w_waiting, w_ready, w_timeout, w_done;
    logic [10:0]       w_op;

    assign w_op = bus.opcode[OPCODE_W-1 -: 11];

    // Opcode class decode; '?' bits are don't-care immediate/register bits.
    always_comb begin
        w_dec_cls = C_NONE;
        casez (w_op)
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: w_dec_cls = C_R;
            11'b1001000100?, 11'b1001001000?, 11'b1101001000?,
            11'b1011001000?, 11'b1101000100?: w_dec_cls = C_I;
            11'b11111000010, 11'b00111000010,
            11'b01111000010, 11'b10111000100: w_dec_cls = C_LD;
            11'b11111000000, 11'b00111000000,
            11'b01111000000, 11'b10111000000: w_dec_cls = C_ST;
            11'b10110100???:                  w_dec_cls = C_CBZ;
            11'b10110101???:                  w_dec_cls = C_CBNZ;
            11'b000101?????:                  w_dec_cls = C_B;
            default:                          w_dec_cls = C_NONE;
        endcase
    end

    // Only FETCH and MEM wait on a memory; each picks its own ready.
    assign w_waiting   = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_ready     = (r_state == S_FETCH) ? bus.imem_ready : bus.dmem_ready;
    assign w_timeout   = TIMEOUT_EN && w_waiting && !w_ready && (r_wait == WAIT_LAST);
    assign w_wait_next = (TIMEOUT_EN && w_waiting && !w_ready && !w_timeout)
                         ? r_wait + 1'b1 : '0;

    always_comb begin
        w_next               = r_state;
        w_done               = 1'b0;
        bus.imem_req         = 1'b0;
        bus.ir_write         = 1'b0;
        bus.pc_write         = 1'b0;
        bus.pc_src           = 1'b0;
        bus.readreg2_control = 1'b0;
        bus.dmem_read        = 1'b0;
        bus.dmem_write       = 1'b0;
        bus.mem_to_reg       = 1'b0;
        bus.reg_write        = 1'b0;
        bus.alu_src          = 1'b0;
        bus.alu_op           = 2'b00;
        bus.update_sreg      = 1'b0;
        bus.illegal_op       = 1'b0;
        bus.halted           = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    w_next       = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                if (w_dec_cls == C_NONE) begin
                    bus.illegal_op = 1'b1;
                    w_next         = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_cls)
                    C_R: begin
                        bus.alu_op = 2'b10;
                        w_next     = S_WB;
                    end
                    C_I: begin
                        bus.alu_src = 1'b1;
                        bus.alu_op  = 2'b10;
                        w_next      = S_WB;
                    end
                    C_LD, C_ST: begin
                        bus.alu_src          = 1'b1;
                        bus.readreg2_control = (r_cls == C_ST);
                        w_next               = S_MEM;
                    end
                    C_CBZ, C_CBNZ: begin
                        bus.readreg2_control = 1'b1;
                        bus.alu_op           = 2'b01;
                        bus.update_sreg      = 1'b1;
                        bus.pc_src           = 1'b1;
                        bus.pc_write         = (r_cls == C_CBZ) ? bus.zero : ~bus.zero;
                        w_done               = 1'b1;
                        w_next               = S_FETCH;
                    end
                    C_B: begin
                        bus.pc_src   = 1'b1;
                        bus.pc_write = 1'b1;
                        w_done       = 1'b1;
                        w_next       = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (r_cls == C_LD) begin
                    bus.dmem_read = 1'b1;
                    if (bus.dmem_ready) w_next = S_WB;
                end else begin
                    bus.dmem_write       = 1'b1;
                    bus.readreg2_control = 1'b1;
                    if (bus.dmem_ready) begin
                        w_done = 1'b1;
                        w_next = S_FETCH;
                    end
                end
                if (w_timeout) w_next = S_HALT;
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = (r_cls == C_LD);
                w_done         = 1'b1;
                w_next         = S_FETCH;
            end
            S_HALT: bus.halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
        // Halt is taken at an instruction boundary; the finishing instruction still retires.
        if (w_next == S_FETCH && bus.halt_req) w_next = S_HALT;
        bus.instr_done = w_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_cls       <= C_NONE;
            r_wait      <= '0;
            r_bus_error <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (r_state == S_DECODE) r_cls <= w_dec_cls;
            if (w_timeout)           r_bus_error <= 1'b1;
            if (w_done)              r_retired <= r_retired + 1'b1;
        end
    end

    assign bus.state         = r_state;
    assign bus.bus_error     = r_bus_error;
    assign bus.retired_count = r_retired;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: each instruction is expanded into a per-cycle trace of inputs and
// expected outputs built from the per-class sequencing rules, then replayed cycle by cycle.
module tb_multicycle_control;
    localparam int TO = 4;
    localparam int CW = 2;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;

    localparam logic [15:0] M_IMEM = 16'h8000, M_IRW = 16'h4000, M_PCW = 16'h2000,
                            M_PCS = 16'h1000, M_RR2 = 16'h0800, M_DRD = 16'h0400,
                            M_DWR = 16'h0200, M_M2R = 16'h0100, M_RW = 16'h0080,
                            M_ASRC = 16'h0040, M_AOP10 = 16'h0020, M_AOP01 = 16'h0010,
                            M_USR = 16'h0008, M_DONE = 16'h0004, M_ILL = 16'h0002,
                            M_HLT = 16'h0001;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_CBZ = 4, K_CBNZ = 5, K_B = 6, K_ILL = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.OPCODE_W(11), .CNT_W(CW)) bus ();

    multicycle_control #(.OPCODE_W(11), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    wire [15:0] dut_ctl = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src,
                           bus.readreg2_control, bus.dmem_read, bus.dmem_write, bus.mem_to_reg,
                           bus.reg_write, bus.alu_src, bus.alu_op, bus.update_sreg,
                           bus.instr_done, bus.illegal_op, bus.halted};

    typedef struct {
        logic [10:0] op;
        logic        zero, irdy, drdy, hq;
        logic [2:0]  st;
        logic [15:0] ctl;
        int          cnt;
        bit          berr;
    } vec_t;

    vec_t        q[$];
    int          m_cnt;
    bit          m_berr;
    logic [10:0] m_op;
    logic        m_zero;
    int          checks = 0;
    int          errors = 0;
    int          step = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [2:0] st, input logic [15:0] ctl,
                                 input logic irdy, input logic drdy, input logic hq);
        vec_t v;
        v.op = m_op; v.zero = m_zero; v.irdy = irdy; v.drdy = drdy; v.hq = hq;
        v.st = st; v.ctl = ctl; v.cnt = m_cnt; v.berr = m_berr;
        q.push_back(v);
        if ((ctl & M_DONE) != 16'h0) m_cnt = (m_cnt + 1) % (1 << CW);
    endfunction

    function automatic void halt_tail(input int n);
        for (int i = 0; i < n; i++) push(S_H, M_HLT, 1'b1, 1'b1, 1'b0);
    endfunction

    // iw/dw: cycles the relevant ready stays low; TO or more such cycles means a timeout.
    function automatic void add_instr(input logic [10:0] op, input int kind, input logic z,
                                      input int iw, input int dw, input bit hlt, input int nh);
        logic [15:0] e;
        m_op = op; m_zero = z;
        for (int i = 0; i < iw; i++) begin
            push(S_F, M_IMEM, 1'b0, 1'b1, 1'b0);
            if (i == TO - 1) begin m_berr = 1'b1; halt_tail(nh); return; end
        end
        push(S_F, M_IMEM | M_IRW | M_PCW, 1'b1, 1'b1, 1'b0);
        if (kind == K_ILL) begin
            push(S_D, M_ILL, 1'b1, 1'b1, hlt);
            if (hlt) halt_tail(nh);
            return;
        end
        push(S_D, 16'h0, 1'b1, 1'b1, 1'b0);
        if (kind == K_CBZ || kind == K_CBNZ || kind == K_B) begin
            if (kind == K_B) e = M_PCS | M_PCW | M_DONE;
            else begin
                e = M_RR2 | M_AOP01 | M_USR | M_PCS | M_DONE;
                if ((kind == K_CBZ) == (z == 1'b1)) e = e | M_PCW;
            end
            push(S_E, e, 1'b1, 1'b1, hlt);
            if (hlt) halt_tail(nh);
            return;
        end
        case (kind)
            K_R:     e = M_AOP10;
            K_I:     e = M_AOP10 | M_ASRC;
            K_LD:    e = M_ASRC;
            default: e = M_ASRC | M_RR2;
        endcase
        push(S_E, e, 1'b1, 1'b1, 1'b0);
        if (kind == K_LD || kind == K_ST) begin
            e = (kind == K_LD) ? M_DRD : (M_DWR | M_RR2);
            for (int i = 0; i < dw; i++) begin
                push(S_M, e, 1'b1, 1'b0, 1'b0);
                if (i == TO - 1) begin m_berr = 1'b1; halt_tail(nh); return; end
            end
            if (kind == K_ST) begin
                push(S_M, e | M_DONE, 1'b1, 1'b1, hlt);
                if (hlt) halt_tail(nh);
                return;
            end
            push(S_M, e, 1'b1, 1'b1, 1'b0);
        end
        push(S_W, M_RW | ((kind == K_LD) ? M_M2R : 16'h0) | M_DONE, 1'b1, 1'b1, hlt);
        if (hlt) halt_tail(nh);
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.halt_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", bus.state, S_F);
        chk("reset_retired", bus.retired_count, 0);
        chk("reset_bus_error", bus.bus_error, 0);
        chk("reset_halted", bus.halted, 0);
        m_cnt = 0; m_berr = 1'b0;
    endtask

    task automatic run_q();
        vec_t v;
        while (q.size() > 0) begin
            v = q.pop_front();
            @(posedge clk); #1;
            reset = 1'b0;
            bus.opcode = v.op; bus.zero = v.zero; bus.imem_ready = v.irdy;
            bus.dmem_ready = v.drdy; bus.halt_req = v.hq;
            @(negedge clk);
            chk($sformatf("state@%0d", step), bus.state, v.st);
            chk($sformatf("ctl@%0d", step), dut_ctl, v.ctl);
            chk($sformatf("retired@%0d", step), bus.retired_count, v.cnt);
            chk($sformatf("bus_error@%0d", step), bus.bus_error, v.berr);
            step++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode = '0; bus.zero = 1'b0; bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0; bus.halt_req = 1'b0;
        m_op = '0; m_zero = 1'b0;

        // Zero-wait ADD, then B so the next FETCH shows the retired count.
        do_reset();
        add_instr(11'b10001011000, K_R, 1'b0, 0, 0, 1'b0, 0);
        chk("pin_add_len", q.size(), 4);
        chk("pin_add_exec", q[2].ctl, 16'h0020);
        chk("pin_add_wb", q[3].ctl, 16'h0084);
        add_instr(11'b00010100011, K_B, 1'b0, 0, 0, 1'b0, 0);
        chk("pin_add_retired", q[4].cnt, 1);
        run_q();

        // Mixed instruction stream, memory waits and an illegal opcode.
        add_instr(11'b11111000010, K_LD, 1'b0, 0, 3, 1'b0, 0);
        chk("pin_ldur_len", q.size(), 8);
        chk("pin_ldur_wb", q[7].ctl, 16'h0184);
        add_instr(11'b10110100101, K_CBZ,  1'b1, 0, 0, 1'b0, 0);
        add_instr(11'b10110100000, K_CBZ,  1'b0, 0, 0, 1'b0, 0);
        add_instr(11'b10110101000, K_CBNZ, 1'b0, 0, 0, 1'b0, 0);
        add_instr(11'b10110101111, K_CBNZ, 1'b1, 0, 0, 1'b0, 0);
        add_instr(11'b10010001000, K_I,    1'b0, 0, 0, 1'b0, 0);
        add_instr(11'b11111000000, K_ST,   1'b0, 0, 1, 1'b0, 0);
        add_instr(11'b00000000000, K_ILL,  1'b0, 0, 0, 1'b0, 0);
        add_instr(11'b11001011000, K_R,    1'b0, TO - 1, 0, 1'b0, 0);
        add_instr(11'b10111000100, K_LD,   1'b0, 0, 0, 1'b0, 0);
        add_instr(11'b00111000000, K_ST,   1'b0, 0, TO - 1, 1'b0, 0);
        add_instr(11'b11010001001, K_I,    1'b0, 0, 0, 1'b0, 0);
        run_q();

        // Halt request in WB of an ADD: it retires, then HALT holds.
        add_instr(11'b10101010000, K_R, 1'b0, 0, 0, 1'b1, 3);
        chk("pin_halt_len", q.size(), 7);
        chk("pin_halt_state", q[4].st, S_H);
        run_q();

        // Stuck instruction memory: timeout into HALT with sticky bus_error.
        do_reset();
        add_instr(11'b10001011000, K_R, 1'b0, 10, 0, 1'b0, 3);
        chk("pin_to_len", q.size(), 7);
        chk("pin_to_berr_before", q[3].berr, 0);
        chk("pin_to_berr_after", q[4].berr, 1);
        run_q();

        // Stuck data memory on a store.
        do_reset();
        add_instr(11'b11111000000, K_ST, 1'b0, 0, 10, 1'b0, 2);
        run_q();

        // Four retires wrap the 2-bit counter; halt after the last branch.
        do_reset();
        for (int i = 0; i < 4; i++)
            add_instr(11'b00010111111, K_B, 1'b0, 0, 0, (i == 3), 2);
        chk("pin_wrap", q[q.size()-1].cnt, 0);
        run_q();

        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
